// File: rtl/apple1_display_sender.sv
// apple1_display_sender
//   Host-side transmitter for the Apple-1 video terminal display port.
//   Characters from an upstream valid/ready source are buffered in a FIFO,
//   presented on the 7-bit display bus with a DA strobe, and paced by the
//   terminal's RDA (ready) signal.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   in_valid     upstream character valid
//   in_data      upstream character (bit 7 ignored)
//   in_ready     FIFO not full; write when in_valid & in_ready
//   da_char      character on the display bus
//   da           data-available strobe to the terminal
//   rda          terminal ready (low while busy), already synchronous to clk
//   busy         state machine active or FIFO non-empty
//   timeout_err  sticky; set when RDA never falls after a strobe
//   fifo_level   number of characters held in the FIFO
module apple1_display_sender #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DA_WIDTH    = 2,
  parameter int ACK_TIMEOUT = 1024,
  parameter bit UPCASE      = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic [6:0]                  da_char,
  output logic                        da,
  input  logic                        rda,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(DA_WIDTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    WAIT_READY
  } state_t;

  state_t        state;
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          wr_en;
  logic          pop;
  logic [6:0]    wr_char;
  logic [SW-1:0] strobe_cnt;
  logic [TW-1:0] ack_cnt;
  logic          in_data_unused;

  assign in_data_unused = in_data[7];

  // Lower-case letters are folded to upper case on the way into the FIFO.
  always_comb begin
    wr_char = in_data[6:0];
    if (UPCASE && (in_data[6:0] >= 7'h61) && (in_data[6:0] <= 7'h7A)) begin
      wr_char = in_data[6:0] - 7'h20;
    end
  end

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !full;
  assign wr_en      = in_valid && !full;
  assign pop        = (state == IDLE) && !empty && rda;
  assign fifo_level = wr_ptr - rd_ptr;
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      da          <= 1'b0;
      da_char     <= '0;
      strobe_cnt  <= '0;
      ack_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            da_char    <= mem[rd_ptr[AW-1:0]];
            da         <= 1'b1;
            strobe_cnt <= SW'(DA_WIDTH - 1);
            state      <= STROBE;
          end
        end
        STROBE: begin
          if (strobe_cnt == '0) begin
            da      <= 1'b0;
            ack_cnt <= TW'(ACK_TIMEOUT - 1);
            state   <= WAIT_ACK;
          end else begin
            strobe_cnt <= strobe_cnt - SW'(1);
          end
        end
        WAIT_ACK: begin
          if (!rda) begin
            state <= WAIT_READY;
          end else if (ack_cnt == '0) begin
            // Terminal never acknowledged: drop the character and move on.
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            ack_cnt <= ack_cnt - TW'(1);
          end
        end
        WAIT_READY: begin
          if (rda) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple1_display_sender.sv
// tb_apple1_display_sender
//   Directed bench for apple1_display_sender with a small terminal model
//   (drops RDA one cycle after DA falls, raises it three cycles later) and a
//   monitor that captures each strobed character.
module tb_apple1_display_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [6:0] da_char;
  logic       da;
  logic       rda;
  logic       busy;
  logic       timeout_err;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;

  // Terminal model controls: term_mode=1 handshakes, 0 holds rda at rda_hold.
  logic term_mode = 1'b1;
  logic rda_hold  = 1'b1;

  logic [6:0] cap[$];

  apple1_display_sender #(
    .FIFO_DEPTH (8),
    .DA_WIDTH   (2),
    .ACK_TIMEOUT(16),
    .UPCASE     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .da_char    (da_char),
    .da         (da),
    .rda        (rda),
    .busy       (busy),
    .timeout_err(timeout_err),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (!busy) break;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_cap(input string tag, input logic [6:0] exp[$]);
    check({tag, "_count"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), {25'd0, cap[i]}, {25'd0, exp[i]});
    end
  endtask

  // Terminal model, acting 2 time units after each edge.
  initial begin
    int   tcnt;
    logic da_q;
    tcnt = 0;
    da_q = 1'b0;
    rda  = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!term_mode) begin
        rda  = rda_hold;
        tcnt = 0;
      end else if (tcnt > 0) begin
        tcnt--;
        rda = (tcnt == 0);
      end else begin
        rda = 1'b1;
        if (da_q && !da) tcnt = 4;
      end
      da_q = da;
    end
  end

  // Monitor: capture a character on each DA rise, verify it stays put.
  initial begin
    logic       mon_q;
    logic [6:0] held;
    mon_q = 1'b0;
    held  = '0;
    forever begin
      step();
      if (da && !mon_q) begin
        cap.push_back(da_char);
        held = da_char;
      end else if (da && mon_q) begin
        check("da_char_stable", {25'd0, da_char}, {25'd0, held});
      end
      mon_q = da;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] exp_q[$];
    int         accepted;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    check("rst_da",          {31'd0, da},          32'd0);
    check("rst_da_char",     {25'd0, da_char},     32'd0);
    check("rst_in_ready",    {31'd0, in_ready},    32'd1);
    check("rst_busy",        {31'd0, busy},        32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_fifo_level",  {28'd0, fifo_level},  32'd0);
    reset = 1'b0;
    step();
    step();

    // Single character with terminal handshake.
    cap.delete();
    in_valid = 1'b1;
    in_data  = 8'h41;
    step();
    in_valid = 1'b0;
    check("t1_da_after_write", {31'd0, da},         32'd0);
    check("t1_level_1",        {28'd0, fifo_level}, 32'd1);
    step();
    check("t1_da_rise",        {31'd0, da},         32'd1);
    check("t1_da_char",        {25'd0, da_char},    32'h41);
    step();
    check("t1_da_hold",        {31'd0, da},         32'd1);
    step();
    check("t1_da_fall",        {31'd0, da},         32'd0);
    wait_idle("t1_idle", 20);
    check("t1_da_char_kept",   {25'd0, da_char},    32'h41);
    check("t1_level_0",        {28'd0, fifo_level}, 32'd0);
    exp_q = '{7'h41};
    check_cap("t1_cap", exp_q);

    // Burst into a stalled terminal, then drain.
    term_mode = 1'b0;
    rda_hold  = 1'b0;
    step();
    cap.delete();
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    check("t2_accepted",  accepted,                 32'd8);
    check("t2_level_8",   {28'd0, fifo_level},      32'd8);
    check("t2_in_ready",  {31'd0, in_ready},        32'd0);
    check("t2_no_strobe", cap.size(),               32'd0);
    term_mode = 1'b1;
    wait_idle("t2_idle", 200);
    exp_q = '{7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37};
    check_cap("t2_cap", exp_q);

    // Upper-case folding, bit 7 dropped first.
    cap.delete();
    in_valid = 1'b1;
    in_data  = 8'h61;
    step();
    in_data  = 8'h7A;
    step();
    in_data  = 8'hE1;
    step();
    in_valid = 1'b0;
    wait_idle("t3_idle", 100);
    exp_q = '{7'h41, 7'h5A, 7'h41};
    check_cap("t3_cap", exp_q);

    // Terminal never acknowledges.
    term_mode = 1'b0;
    rda_hold  = 1'b1;
    step();
    cap.delete();
    in_valid = 1'b1;
    in_data  = 8'h42;
    step();
    in_data  = 8'h43;
    step();
    in_valid = 1'b0;
    check("t4_da_rise",    {31'd0, da},          32'd1);
    check("t4_da_char",    {25'd0, da_char},     32'h42);
    step();
    step();
    check("t4_da_fall",    {31'd0, da},          32'd0);
    repeat (15) step();
    check("t4_err_before", {31'd0, timeout_err}, 32'd0);
    step();
    check("t4_err_set",    {31'd0, timeout_err}, 32'd1);
    step();
    check("t4_next_da",    {31'd0, da},          32'd1);
    check("t4_next_char",  {25'd0, da_char},     32'h43);
    wait_idle("t4_idle", 60);
    check("t4_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Write and pop on the same edge.
    rda_hold = 1'b0;
    step();
    cap.delete();
    in_valid = 1'b1;
    in_data  = 8'h50;
    step();
    in_data  = 8'h51;
    step();
    in_data  = 8'h52;
    step();
    in_valid = 1'b0;
    check("t5_level_3_pre", {28'd0, fifo_level}, 32'd3);
    term_mode = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h53;
    step();
    in_valid = 1'b0;
    check("t5_level_3_post", {28'd0, fifo_level}, 32'd3);
    check("t5_da",           {31'd0, da},         32'd1);
    check("t5_da_char",      {25'd0, da_char},    32'h50);
    wait_idle("t5_idle", 100);
    exp_q = '{7'h50, 7'h51, 7'h52, 7'h53};
    check_cap("t5_cap", exp_q);

    // Asynchronous reset while strobing.
    in_valid = 1'b1;
    in_data  = 8'h44;
    step();
    in_data  = 8'h45;
    step();
    in_valid = 1'b0;
    check("t6_da_pre",    {31'd0, da},         32'd1);
    check("t6_level_pre", {28'd0, fifo_level}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_da_async",       {31'd0, da},          32'd0);
    check("t6_level_async",    {28'd0, fifo_level},  32'd0);
    check("t6_err_async",      {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cap.delete();
    repeat (10) step();
    check("t6_no_spurious", cap.size(),            32'd0);
    check("t6_in_ready",    {31'd0, in_ready},     32'd1);
    check("t6_busy",        {31'd0, busy},         32'd0);
    check("t6_da_low",      {31'd0, da},           32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
